// File: rtl/lock_pkg.sv
// Shared definitions for the parametrised combination lock: state encoding
// and active-low seven-segment glyphs (bit 6 = g, bit 0 = a).
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_ERROR   = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_T     = 7'h07;

  // Anything outside 0..9 renders as a dash.
  function automatic logic [6:0] seg_decimal(input logic [31:0] v);
    case (v)
      32'd0:   seg_decimal = SEG_0;
      32'd1:   seg_decimal = SEG_1;
      32'd2:   seg_decimal = SEG_2;
      32'd3:   seg_decimal = SEG_3;
      32'd4:   seg_decimal = SEG_4;
      32'd5:   seg_decimal = SEG_5;
      32'd6:   seg_decimal = SEG_6;
      32'd7:   seg_decimal = SEG_7;
      32'd8:   seg_decimal = SEG_8;
      32'd9:   seg_decimal = SEG_9;
      default: seg_decimal = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/lock_msg_display.sv
// Combinational message generator: maps lock state and recent entry digits
// onto six active-low seven-segment digits (segs[0] = HEX0).
module lock_msg_display
  import lock_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  lock_state_e              state,
  input  logic [6*DIGIT_W-1:0]     digits,
  input  logic [2:0]               shown,
  output logic [5:0][6:0]          segs
);

  always_comb begin
    segs = {6{SEG_BLANK}};
    case (state)
      ST_ENTRY: begin
        // Newest digit sits in the low slot and lands on HEX0.
        for (int i = 0; i < 6; i++) begin
          if (3'(i) < shown) begin
            segs[i] = seg_decimal(32'(digits[i*DIGIT_W +: DIGIT_W]));
          end
        end
      end
      ST_OPEN: begin
        segs[3] = SEG_O;
        segs[2] = SEG_P;
        segs[1] = SEG_E;
        segs[0] = SEG_N;
      end
      ST_CLOSED: begin
        segs[5] = SEG_C;
        segs[4] = SEG_L;
        segs[3] = SEG_O;
        segs[2] = SEG_S;
        segs[1] = SEG_E;
        segs[0] = SEG_D;
      end
      ST_ERROR: begin
        segs[4] = SEG_E;
        segs[3] = SEG_R;
        segs[2] = SEG_R;
        segs[1] = SEG_0;
        segs[0] = SEG_R;
      end
      ST_LOCKOUT: begin
        segs[5] = SEG_L;
        segs[4] = SEG_O;
        segs[3] = SEG_C;
        segs[2] = SEG_O;
        segs[1] = SEG_U;
        segs[0] = SEG_T;
      end
      default: segs = {6{SEG_BLANK}};
    endcase
  end

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised combination lock core: digit entry, programmable code,
// failure counting with timed lockout, and registered HEX status display.
module combo_lock_param
  import lock_pkg::*;
#(
  parameter int                          DIGIT_W        = 4,
  parameter int                          CODE_LEN       = 6,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 24'h838482,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                digit_valid,
  input  logic                                clear,
  input  logic                                prog_en,
  input  logic                                relock,
  output logic                                unlocked,
  output logic [2:0]                          state,
  output logic [$clog2(CODE_LEN+1)-1:0]       digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]      fail_count,
  output logic [6:0]                          HEX0,
  output logic [6:0]                          HEX1,
  output logic [6:0]                          HEX2,
  output logic [6:0]                          HEX3,
  output logic [6:0]                          HEX4,
  output logic [6:0]                          HEX5
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CW     = $clog2(CODE_LEN + 1);
  localparam int FW     = $clog2(MAX_TRIES + 1);
  localparam int LW     = $clog2(LOCKOUT_CYCLES + 1);

  lock_state_e       state_q, state_n;
  logic [CW-1:0]     count_q, count_n;
  logic [FW-1:0]     fail_q, fail_n;
  logic [LW-1:0]     lock_q, lock_n;
  logic              bad_q, bad_n;
  logic              unlocked_q;
  logic [CODE_W-1:0] code_q, code_n;
  logic [CODE_W-1:0] entry_q, entry_n;
  logic [CODE_W-1:0] shadow_q, shadow_n;
  logic [5:0][6:0]   hex_q, hex_n;
  logic [2:0]        shown;
  logic              is_dec;
  logic              last_digit;
  logic              bad_any;

  function automatic logic [CODE_W-1:0] shift_in(input logic [CODE_W-1:0] reg_v,
                                                 input logic [DIGIT_W-1:0] d);
    shift_in = (reg_v << DIGIT_W) | CODE_W'(d);
  endfunction

  assign is_dec     = (32'(digit_in) <= 32'd9);
  assign last_digit = (count_q == CW'(CODE_LEN - 1));

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    fail_n   = fail_q;
    lock_n   = lock_q;
    bad_n    = bad_q;
    code_n   = code_q;
    entry_n  = entry_q;
    shadow_n = shadow_q;
    bad_any  = bad_q | ~is_dec;
    case (state_q)
      ST_ENTRY: begin
        if (digit_valid) begin
          entry_n = shift_in(entry_q, digit_in);
          if (last_digit) begin
            count_n = '0;
            bad_n   = 1'b0;
            if (!bad_any && entry_n == code_q) begin
              state_n = ST_OPEN;
              fail_n  = '0;
            end else if (32'(fail_q) + 32'd1 >= 32'(MAX_TRIES)) begin
              // The failure that hits the limit skips CLOSED/ERROR entirely.
              state_n = ST_LOCKOUT;
              fail_n  = FW'(MAX_TRIES);
              lock_n  = LW'(LOCKOUT_CYCLES);
            end else begin
              state_n = bad_any ? ST_ERROR : ST_CLOSED;
              fail_n  = fail_q + 1'b1;
            end
          end else begin
            count_n = count_q + 1'b1;
            bad_n   = bad_any;
          end
        end
      end
      ST_OPEN: begin
        if (relock) begin
          state_n = ST_ENTRY;
          count_n = '0;
        end else if (!prog_en) begin
          count_n = '0;
        end else if (digit_valid) begin
          if (!is_dec) begin
            count_n = '0;
          end else begin
            shadow_n = shift_in(shadow_q, digit_in);
            if (last_digit) begin
              code_n  = shadow_n;
              count_n = '0;
            end else begin
              count_n = count_q + 1'b1;
            end
          end
        end
      end
      ST_CLOSED, ST_ERROR: begin
        if (clear) begin
          state_n = ST_ENTRY;
          count_n = '0;
        end
      end
      ST_LOCKOUT: begin
        if (lock_q <= LW'(1)) begin
          state_n = ST_ENTRY;
          lock_n  = '0;
          fail_n  = '0;
        end else begin
          lock_n = lock_q - 1'b1;
        end
      end
      default: begin
        state_n = ST_ENTRY;
        count_n = '0;
      end
    endcase
  end

  // Display is driven from next-state values so it registers alongside state.
  assign shown = (32'(count_n) >= 32'd6) ? 3'd6 : 3'(count_n);

  lock_msg_display #(
    .DIGIT_W (DIGIT_W)
  ) u_display (
    .state  (state_n),
    .digits ((6*DIGIT_W)'(entry_n)),
    .shown  (shown),
    .segs   (hex_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ENTRY;
      count_q    <= '0;
      fail_q     <= '0;
      lock_q     <= '0;
      bad_q      <= 1'b0;
      unlocked_q <= 1'b0;
      code_q     <= DEFAULT_CODE;
      hex_q      <= {6{SEG_BLANK}};
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      fail_q     <= fail_n;
      lock_q     <= lock_n;
      bad_q      <= bad_n;
      unlocked_q <= (state_n == ST_OPEN);
      code_q     <= code_n;
      hex_q      <= hex_n;
    end
  end

  always_ff @(posedge clk) begin
    entry_q  <= entry_n;
    shadow_q <= shadow_n;
  end

  assign state       = state_q;
  assign digit_count = count_q;
  assign fail_count  = fail_q;
  assign unlocked    = unlocked_q;
  assign HEX0        = hex_q[0];
  assign HEX1        = hex_q[1];
  assign HEX2        = hex_q[2];
  assign HEX3        = hex_q[3];
  assign HEX4        = hex_q[4];
  assign HEX5        = hex_q[5];

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param: entry, failure, lockout, programming.
module tb_combo_lock_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic       prog_en;
  logic       relock;
  logic       unlocked;
  logic [2:0] state;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int errors = 0;
  int checks = 0;

  localparam logic [41:0] H_BLANK  = {6{7'h7F}};
  localparam logic [41:0] H_OPEN   = {7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B};
  localparam logic [41:0] H_CLOSED = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
  localparam logic [41:0] H_ERROR  = {7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F};
  localparam logic [41:0] H_LOCK   = {7'h47, 7'h40, 7'h46, 7'h40, 7'h41, 7'h07};

  combo_lock_param dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .clear       (clear),
    .prog_en     (prog_en),
    .relock      (relock),
    .unlocked    (unlocked),
    .state       (state),
    .digit_count (digit_count),
    .fail_count  (fail_count),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hex_all();
    return 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
  endfunction

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter6(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) send_digit(c[i*4 +: 4]);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; digit_in = '0; digit_valid = 1'b0;
    clear = 1'b0; prog_en = 1'b0; relock = 1'b0;

    do_reset();
    check("rst_state", 64'(state), 64'd0);
    check("rst_hex", hex_all(), 64'(H_BLANK));
    check("rst_count", 64'(digit_count), 64'd0);
    check("rst_fail", 64'(fail_count), 64'd0);
    check("rst_unlocked", 64'(unlocked), 64'd0);

    // Correct default code opens the lock.
    enter6(24'h838482);
    check("open_state", 64'(state), 64'd1);
    check("open_unlocked", 64'(unlocked), 64'd1);
    check("open_hex", hex_all(), 64'(H_OPEN));
    check("open_fail", 64'(fail_count), 64'd0);
    pulse_relock();
    check("relock_state", 64'(state), 64'd0);
    check("relock_unlocked", 64'(unlocked), 64'd0);

    // Partial entry display, then wrong code.
    send_digit(4'h8); send_digit(4'h3); send_digit(4'h8);
    check("mid_count", 64'(digit_count), 64'd3);
    check("mid_hex", hex_all(), 64'({7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h30, 7'h00}));
    send_digit(4'h9); send_digit(4'h8); send_digit(4'h2);
    check("closed_state", 64'(state), 64'd2);
    check("closed_hex", hex_all(), 64'(H_CLOSED));
    check("closed_fail", 64'(fail_count), 64'd1);
    check("closed_count", 64'(digit_count), 64'd0);
    pulse_clear();
    check("clear_state", 64'(state), 64'd0);
    check("clear_hex", hex_all(), 64'(H_BLANK));

    // Non-decimal digit: dash on display, then ERROR.
    send_digit(4'h8); send_digit(4'h3); send_digit(4'h8); send_digit(4'h4); send_digit(4'hA);
    check("bad_count", 64'(digit_count), 64'd5);
    check("bad_hex", hex_all(), 64'({7'h7F, 7'h00, 7'h30, 7'h00, 7'h19, 7'h3F}));
    send_digit(4'h2);
    check("err_state", 64'(state), 64'd3);
    check("err_hex", hex_all(), 64'(H_ERROR));
    check("err_fail", 64'(fail_count), 64'd2);
    send_digit(4'h1);
    check("err_hold", 64'(state), 64'd3);
    check("err_hold_count", 64'(digit_count), 64'd0);
    pulse_clear();
    check("err_clear", 64'(state), 64'd0);

    // Three consecutive failures lead to a 16-cycle lockout.
    do_reset();
    enter6(24'h838982); pulse_clear();
    enter6(24'h838982); pulse_clear();
    enter6(24'h838982);
    check("lock_state", 64'(state), 64'd4);
    check("lock_hex", hex_all(), 64'(H_LOCK));
    check("lock_fail", 64'(fail_count), 64'd3);
    n = 1;
    while (state == 3'd4 && n < 40) begin
      digit_in = 4'h8; digit_valid = 1'b1; clear = 1'b1;
      tick();
      if (state == 3'd4) n++;
    end
    digit_valid = 1'b0; clear = 1'b0;
    check("lock_len", 64'(n), 64'd16);
    check("lock_exit_state", 64'(state), 64'd0);
    check("lock_exit_fail", 64'(fail_count), 64'd0);
    check("lock_exit_count", 64'(digit_count), 64'd0);

    // Reset in the middle of a lockout.
    enter6(24'h838982); pulse_clear();
    enter6(24'h838982); pulse_clear();
    enter6(24'h838982);
    tick(); tick(); tick();
    check("lock2_state", 64'(state), 64'd4);
    reset = 1'b1;
    tick();
    check("lock_rst_state", 64'(state), 64'd0);
    check("lock_rst_fail", 64'(fail_count), 64'd0);
    reset = 1'b0;

    // Program 123456 while open.
    enter6(24'h838482);
    check("prog_open", 64'(state), 64'd1);
    prog_en = 1'b1;
    send_digit(4'h1); send_digit(4'h2); send_digit(4'h3);
    check("prog_mid_count", 64'(digit_count), 64'd3);
    send_digit(4'h4); send_digit(4'h5); send_digit(4'h6);
    check("prog_done_count", 64'(digit_count), 64'd0);
    check("prog_done_state", 64'(state), 64'd1);
    prog_en = 1'b0;
    pulse_relock();
    enter6(24'h838482);
    check("old_code_closed", 64'(state), 64'd2);
    pulse_clear();
    enter6(24'h123456);
    check("new_code_open", 64'(state), 64'd1);
    check("new_code_fail", 64'(fail_count), 64'd0);
    pulse_relock();
    do_reset();
    enter6(24'h838482);
    check("rst_default_open", 64'(state), 64'd1);

    // Aborted programming leaves the code untouched.
    prog_en = 1'b1;
    send_digit(4'h1); send_digit(4'h2); send_digit(4'hB);
    check("abort_count", 64'(digit_count), 64'd0);
    send_digit(4'h3); send_digit(4'h4); send_digit(4'h5);
    prog_en = 1'b0;
    tick();
    pulse_relock();
    enter6(24'h123456);
    check("abort_new_closed", 64'(state), 64'd2);
    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'h5;
    tick();
    clear = 1'b0; digit_valid = 1'b0;
    check("clear_digit_state", 64'(state), 64'd0);
    check("clear_digit_count", 64'(digit_count), 64'd0);
    enter6(24'h838482);
    check("abort_old_open", 64'(state), 64'd1);

    // relock wins over a coincident digit.
    prog_en = 1'b1; relock = 1'b1; digit_valid = 1'b1; digit_in = 4'h7;
    tick();
    prog_en = 1'b0; relock = 1'b0; digit_valid = 1'b0;
    check("relock_prio_state", 64'(state), 64'd0);
    check("relock_prio_count", 64'(digit_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/combo_lock_param.md
# combo_lock_param

Parametrised, clocked successor to the fixed six-digit board lock. It accepts one code digit per `digit_valid` strobe and compares the entry against a programmable code register. It counts failed attempts and enforces a timed lockout. It drives six active-low seven-segment digits with the status messages. It sits between the board top (switches and keys) and the HEX displays, and replaces the hard-wired comparator with a reusable core.

## Interface
- `DIGIT_W`, 4: bits per code digit.
- `CODE_LEN`, 6: digits per code, range 1..8.
- `DEFAULT_CODE`, 24'h838482: code loaded at reset. The first-entered digit is the most-significant digit.
- `MAX_TRIES`, 3: consecutive failed attempts before lockout, ≥1.
- `LOCKOUT_CYCLES`, 16: lockout duration in clock cycles, ≥1.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit_in`  in  DIGIT_W  entered digit. Decimal 0..9 is valid; any other value is non-decimal.
- `digit_valid`  in  1  qualifies `digit_in` for one cycle.
- `clear`  in  1  leaves the CLOSED or ERROR state.
- `prog_en`  in  1  while OPEN, routes digits to code programming.
- `relock`  in  1  leaves OPEN.
- `unlocked`  out  1  high only in OPEN.
- `state`  out  3  0 ENTRY, 1 OPEN, 2 CLOSED, 3 ERROR, 4 LOCKOUT.
- `digit_count`  out  $clog2(CODE_LEN+1)  digits accepted in the current entry or programming pass.
- `fail_count`  out  $clog2(MAX_TRIES+1)  consecutive failures.
- `HEX0`..`HEX5`  out  7 each  active-low segments, bit 6 = g.

## Operation
- Reset:
  - state goes to ENTRY; code register loads `DEFAULT_CODE`.
  - `digit_count`, `fail_count`, lockout counter and the bad-digit flag all go to 0.
  - HEX outputs go blank (7'h7F).
- ENTRY:
  - Each `digit_valid` shifts `digit_in` into the entry register and increments `digit_count`.
  - A non-decimal digit sets the sticky bad flag.
  - On the CODE_LEN-th digit:
    - bad flag set → ERROR;
    - else entry equals code → OPEN, and `fail_count` clears;
    - else → CLOSED.
  - `digit_count` returns to 0 on the transition.
- CLOSED / ERROR:
  - Entering either state increments `fail_count`.
  - If `fail_count` reaches MAX_TRIES, go to LOCKOUT instead.
  - Otherwise hold until `clear`, then return to ENTRY.
  - Digits in these states are ignored.
- LOCKOUT:
  - Counter loads LOCKOUT_CYCLES and decrements every cycle.
  - When the counter reaches 0, return to ENTRY and clear `fail_count`.
  - `digit_valid`, `clear` and `relock` are ignored.
- OPEN:
  - `relock` → ENTRY.
  - With `prog_en` high, each `digit_valid` shifts into a shadow register.
  - On the CODE_LEN-th programming digit, the shadow register is copied atomically to the code register and `digit_count` clears.
  - The pass aborts, with the code unchanged, on any of: a non-decimal digit, `prog_en` falling, or `relock`.
  - Digits with `prog_en` low are ignored.
- Display:
  - ENTRY: the last min(digit_count, 6) digits, newest on HEX0; unused digits blank; non-decimal digits shown as "-".
  - OPEN: "OPEn" on HEX3..0.
  - CLOSED: "CLOSEd" on HEX5..0.
  - ERROR: "Err0r" on HEX4..0.
  - LOCKOUT: "LOCOUt".
  - All unused digits blank.

## Timing
- Every output is registered. The state and the display update in the cycle after the final digit's `digit_valid` edge, i.e. 1-cycle latency.
- Priority when events coincide: `reset` > `relock` > `clear` > `digit_valid`. The losing digit is dropped and is not counted.
- The lockout lasts exactly LOCKOUT_CYCLES cycles in LOCKOUT. `state` = 0 appears on the cycle after that.
- A reset mid-entry, mid-programming or mid-lockout discards the partial state. A reset reloads `DEFAULT_CODE` even if the code was reprogrammed.
- `digit_valid` may be high on consecutive cycles. Every strobed cycle is one digit.

## Structure
- Shared package `lock_pkg`:
  - the state enum;
  - the segment constants (blank, dash, 0–9, letters O P E n C L S d r U t).
- Sub-module `lock_msg_display`: combinational, maps state plus the entry digits to HEX0..HEX5.
- The FSM, counters and code registers stay in `combo_lock_param`.

## Test plan
- Reset, then digits 8,3,8,4,8,2 → `state`=1, `unlocked`=1, HEX3..0 show "OPEn", `fail_count`=0.
- Digits 8,3,8,9,8,2 → `state`=2, "CLOSEd", `fail_count`=1. Then `clear` → `state`=0, HEX blank.
- Digits 8,3,8,4,A,2 → `state`=3, "Err0r". A further `digit_valid` without `clear` leaves the state unchanged.
- Three wrong codes in a row → `state`=4 for exactly 16 cycles while digits are ignored, then `state`=0 and `fail_count`=0. Reset asserted mid-lockout → ENTRY on the next cycle.
- Open, then `prog_en` with digits 1,2,3,4,5,6, then `relock`:
  - 838482 → CLOSED;
  - 123456 → OPEN.
  - Reset, then 838482 → OPEN.
- Open, then program 1,2,B → abort, and the code is still 838482. `clear` and `digit_valid` asserted in the same cycle in CLOSED → ENTRY with `digit_count`=0.
